// File: rtl/fast_square_sweep_ctrl.sv
// fast_square_sweep_ctrl: frequency-sweep sequencer for the fast-square receive path.
// Walks NUM_FREQ_STEPS tones through RESET -> (SETTLE -> RECORD -> STEP)* and drives the
// RX chain controls plus the synthesizer step pulse train.
// Optional build macro FSQ_LOCK_TIMEOUT_EN: bounds the PLL-lock wait in SETTLE; on timeout
// the sweep restarts from RESET and the sticky lock_err flag is raised. Without the macro,
// SETTLE waits for lock indefinitely and lock_err is tied low.
module fast_square_sweep_ctrl #(
  parameter int NUM_FREQ_STEPS     = 32,
  parameter int STEP_W             = 8,
  parameter int CNT_W              = 20,
  parameter int RESET_TICKS        = 1048575,
  parameter int SETTLE_TICKS       = 640,
  parameter int RECORD_TICKS       = 15000,
  parameter int STEP_PULSES        = 2,
  parameter int STEP_PULSE_TICKS   = 10,
  parameter int STEP_GAP_TICKS     = 10,
  parameter int LOCK_TIMEOUT_TICKS = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              freq_step_reset_in,
  input  logic              pll_locked,
  output logic              rx_reset,
  output logic              rx_record,
  output logic              rx_next,
  output logic              freq_step_out,
  output logic [STEP_W-1:0] step_index,
  output logic              busy,
  output logic              sweep_done,
  output logic [15:0]       sweep_count,
  output logic              lock_err
);

  // Total STEP length: pulses plus the gaps between them (no trailing gap).
  localparam int STEP_TICKS = STEP_PULSES * STEP_PULSE_TICKS
                            + (STEP_PULSES - 1) * STEP_GAP_TICKS;

  localparam logic [CNT_W-1:0]  RESET_LAST  = CNT_W'(RESET_TICKS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0]  RECORD_LAST = CNT_W'(RECORD_TICKS - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST   = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST  = CNT_W'(STEP_PULSE_TICKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(STEP_GAP_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [STEP_W-1:0] LAST_TONE   = STEP_W'(NUM_FREQ_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);
  localparam logic [15:0]       SWEEP_ONE   = 16'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_SETTLE = 3'd2,
    S_RECORD = 3'd3,
    S_STEP   = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             restart;
  logic             step_adv;
  logic             lock_timeout;
  logic             start_taken;

  // Pulse/gap sequencer inside STEP; seg_cnt counts within the current pulse or gap.
  logic [CNT_W-1:0] seg_cnt;
  logic             in_gap;
  logic             step_high;

  // A start is only honoured from IDLE and never alongside abort or a resync.
  assign start_taken = (state == S_IDLE) && start && !abort && !freq_step_reset_in;

`ifdef FSQ_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT_TICKS - 1);

  logic [CNT_W-1:0] lock_cnt;

  // The wait for lock expires on the LOCK_TIMEOUT_TICKS-th consecutive unlocked cycle.
  assign lock_timeout = (state == S_SETTLE) && !pll_locked && (lock_cnt == LOCK_LAST);

  // Unlocked-cycle counter: only runs while sitting in SETTLE without lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_cnt <= '0;
    end else if ((state != S_SETTLE) || (next_state != S_SETTLE) || pll_locked) begin
      lock_cnt <= '0;
    end else begin
      lock_cnt <= lock_cnt + CNT_ONE;
    end
  end

  // Sticky timeout flag; a fresh start from IDLE clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_err <= 1'b0;
    end else if (lock_timeout && !abort && !freq_step_reset_in) begin
      lock_err <= 1'b1;
    end else if (start_taken) begin
      lock_err <= 1'b0;
    end
  end
`else
  assign lock_timeout = 1'b0;
  assign lock_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort beats resync, resync beats lock timeout and normal flow.
  always_comb begin
    next_state = state;
    restart    = 1'b0;
    step_adv   = 1'b0;
    sweep_done = 1'b0;
    if (abort) begin
      next_state = S_IDLE;
    end else if (freq_step_reset_in) begin
      next_state = S_RESET;
      restart    = 1'b1;
    end else if (lock_timeout) begin
      next_state = S_RESET;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) next_state = S_RESET;
        end
        S_RESET: begin
          if (cnt == RESET_LAST) next_state = S_SETTLE;
        end
        S_SETTLE: begin
          if ((cnt >= SETTLE_LAST) && pll_locked) next_state = S_RECORD;
        end
        S_RECORD: begin
          if (cnt == RECORD_LAST) begin
            if (step_index == LAST_TONE) begin
              sweep_done = 1'b1;
              next_state = continuous ? S_RESET : S_IDLE;
            end else begin
              next_state = S_STEP;
            end
          end
        end
        S_STEP: begin
          if (cnt == STEP_LAST) begin
            next_state = S_SETTLE;
            step_adv   = 1'b1;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Shared phase counter: restarts on any state change, including a resync into RESET.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if ((next_state != state) || restart) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Tone index: zeroed whenever the sweep (re)starts, advanced when a STEP completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_index <= '0;
    end else if (next_state == S_RESET) begin
      step_index <= '0;
    end else if (step_adv) begin
      step_index <= step_index + STEP_ONE;
    end
  end

  // Completed-sweep counter, wrapping naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      sweep_count <= '0;
    end else if (sweep_done) begin
      sweep_count <= sweep_count + SWEEP_ONE;
    end
  end

  // Pulse/gap sequencing for the step waveform; held cleared outside an ongoing STEP.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_cnt <= '0;
      in_gap  <= 1'b0;
    end else if ((state != S_STEP) || (next_state != S_STEP)) begin
      seg_cnt <= '0;
      in_gap  <= 1'b0;
    end else if (!in_gap) begin
      if (seg_cnt == PULSE_LAST) begin
        seg_cnt <= '0;
        in_gap  <= 1'b1;
      end else begin
        seg_cnt <= seg_cnt + CNT_ONE;
      end
    end else begin
      if (seg_cnt == GAP_LAST) begin
        seg_cnt <= '0;
        in_gap  <= 1'b0;
      end else begin
        seg_cnt <= seg_cnt + CNT_ONE;
      end
    end
  end

  assign step_high = (state == S_STEP) && !in_gap;

  // Registered step output, one cycle behind the STEP decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      freq_step_out <= 1'b0;
    end else begin
      freq_step_out <= step_high;
    end
  end

  assign rx_reset  = (state == S_RESET);
  assign rx_record = (state == S_RECORD);
  assign rx_next   = (state == S_RECORD) && (cnt == RECORD_LAST) && (step_index != LAST_TONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed testbench for fast_square_sweep_ctrl with a 3-tone, short-tick configuration.
// Timeline indices below count cycles from the one in which start is driven (index 0).
module tb_fast_square_sweep_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        abort = 1'b0;
  logic        freq_step_reset_in = 1'b0;
  logic        pll_locked = 1'b1;
  logic        rx_reset, rx_record, rx_next, freq_step_out;
  logic [7:0]  step_index;
  logic        busy, sweep_done, lock_err;
  logic [15:0] sweep_count;

  int checks = 0;
  int passed = 0;

  fast_square_sweep_ctrl #(
    .NUM_FREQ_STEPS(3), .STEP_W(8), .CNT_W(20), .RESET_TICKS(16), .SETTLE_TICKS(4),
    .RECORD_TICKS(8), .STEP_PULSES(2), .STEP_PULSE_TICKS(2), .STEP_GAP_TICKS(3),
    .LOCK_TIMEOUT_TICKS(10)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .freq_step_reset_in(freq_step_reset_in), .pll_locked(pll_locked),
    .rx_reset(rx_reset), .rx_record(rx_record), .rx_next(rx_next),
    .freq_step_out(freq_step_out), .step_index(step_index), .busy(busy),
    .sweep_done(sweep_done), .sweep_count(sweep_count), .lock_err(lock_err)
  );

  always #5 clock = ~clock;

  // Per-cycle trace of the outputs, sampled on the falling edge.
  logic         mon_en = 1'b0;
  int           mon_cyc = 0;
  logic [511:0] lg_rst, lg_rec, lg_next, lg_fs, lg_busy, lg_done, lg_sz, lg_le;

  always @(negedge clock) begin
    if (!mon_en) begin
      mon_cyc <= 0;
      lg_rst <= '0; lg_rec <= '0; lg_next <= '0; lg_fs <= '0;
      lg_busy <= '0; lg_done <= '0; lg_sz <= '0; lg_le <= '0;
    end else if (mon_cyc < 512) begin
      lg_rst[mon_cyc]  <= rx_reset;
      lg_rec[mon_cyc]  <= rx_record;
      lg_next[mon_cyc] <= rx_next;
      lg_fs[mon_cyc]   <= freq_step_out;
      lg_busy[mon_cyc] <= busy;
      lg_done[mon_cyc] <= sweep_done;
      lg_sz[mon_cyc]   <= (step_index == 8'd0);
      lg_le[mon_cyc]   <= lock_err;
      mon_cyc <= mon_cyc + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic begin_capture();
    mon_en = 1'b0;
    adv(2);
  endtask

  function automatic int rises(input logic [511:0] v);
    int n = 0;
    for (int i = 1; i < 512; i++) if (v[i] && !v[i-1]) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    adv(3);
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({rx_reset, rx_record, rx_next, freq_step_out, busy, sweep_done, lock_err} !== 7'b0) $display("FAIL reset_outputs: got %b expected 0000000", {rx_reset, rx_record, rx_next, freq_step_out, busy, sweep_done, lock_err}); else passed++;
    checks++; if (step_index !== 8'd0) $display("FAIL reset_step_index: got %0d expected 0", step_index); else passed++;
    checks++; if (sweep_count !== 16'd0) $display("FAIL reset_sweep_count: got %0d expected 0", sweep_count); else passed++;
  endtask

  task automatic test_single_sweep();
    begin_capture();
    continuous = 1'b0; pll_locked = 1'b1; start = 1'b1; mon_en = 1'b1;
    adv(1);  start = 1'b0;
    adv(29); start = 1'b1;   // start during STEP must be ignored
    adv(1);  start = 1'b0;
    adv(49); mon_en = 1'b0;
    checks++; if ($countones(lg_rst) !== 16) $display("FAIL single_rst_len: got %0d expected 16", $countones(lg_rst)); else passed++;
    checks++; if ({lg_rst[17:16], lg_rst[1:0]} !== 4'b0110) $display("FAIL single_rst_edges: got %b expected 0110", {lg_rst[17:16], lg_rst[1:0]}); else passed++;
    checks++; if ($countones(lg_rec) !== 24) $display("FAIL single_rec_len: got %0d expected 24", $countones(lg_rec)); else passed++;
    checks++; if (rises(lg_rec) !== 3) $display("FAIL single_rec_windows: got %0d expected 3", rises(lg_rec)); else passed++;
    checks++; if (lg_rec[21:20] !== 2'b10) $display("FAIL single_rec_start: got %b expected 10", lg_rec[21:20]); else passed++;
    checks++; if ($countones(lg_next) !== 2) $display("FAIL single_next_count: got %0d expected 2", $countones(lg_next)); else passed++;
    checks++; if ({lg_next[47], lg_next[28]} !== 2'b11) $display("FAIL single_next_pos: got %b expected 11", {lg_next[47], lg_next[28]}); else passed++;
    checks++; if ($countones(lg_fs) !== 8) $display("FAIL single_fs_count: got %0d expected 8", $countones(lg_fs)); else passed++;
    checks++; if (lg_fs[37:29] !== 9'b011000110) $display("FAIL single_fs_pattern: got %b expected 011000110", lg_fs[37:29]); else passed++;
    checks++; if ($countones(lg_busy) !== 66) $display("FAIL single_busy_len: got %0d expected 66", $countones(lg_busy)); else passed++;
    checks++; if (lg_busy[67:66] !== 2'b01) $display("FAIL single_busy_end: got %b expected 01", lg_busy[67:66]); else passed++;
    checks++; if ($countones(lg_done) !== 1) $display("FAIL single_done_count: got %0d expected 1", $countones(lg_done)); else passed++;
    checks++; if (lg_done[66] !== 1'b1) $display("FAIL single_done_pos: got %b expected 1", lg_done[66]); else passed++;
    checks++; if (sweep_count !== 16'd1) $display("FAIL single_sweep_count: got %0d expected 1", sweep_count); else passed++;
    checks++; if (step_index !== 8'd2) $display("FAIL single_step_index: got %0d expected 2", step_index); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_lock_gating();
    begin_capture();
    start = 1'b1; mon_en = 1'b1;
    adv(1);  start = 1'b0;
    adv(35); pll_locked = 1'b0;   // cycles 36..55 unlocked (second SETTLE)
    adv(20); pll_locked = 1'b1;   // lock back in cycle 56
    adv(40); mon_en = 1'b0;
    checks++; if (lg_rec[65:56] !== 10'b0111111110) $display("FAIL lock_rec_window: got %b expected 0111111110", lg_rec[65:56]); else passed++;
    checks++; if ($countones(lg_rec) !== 24) $display("FAIL lock_rec_len: got %0d expected 24", $countones(lg_rec)); else passed++;
    checks++; if ({lg_next[64], lg_next[28]} !== 2'b11) $display("FAIL lock_next_pos: got %b expected 11", {lg_next[64], lg_next[28]}); else passed++;
    checks++; if (lg_fs[73:65] !== 9'b011000110) $display("FAIL lock_fs_pattern: got %b expected 011000110", lg_fs[73:65]); else passed++;
    checks++; if (lg_done[83] !== 1'b1) $display("FAIL lock_done_pos: got %b expected 1", lg_done[83]); else passed++;
    checks++; if ($countones(lg_busy) !== 83) $display("FAIL lock_busy_len: got %0d expected 83", $countones(lg_busy)); else passed++;
    checks++; if (sweep_count !== 16'd2) $display("FAIL lock_sweep_count: got %0d expected 2", sweep_count); else passed++;
  endtask

  task automatic test_continuous();
    begin_capture();
    continuous = 1'b1; start = 1'b1; mon_en = 1'b1;
    adv(1);   start = 1'b0;
    adv(149); continuous = 1'b0;  // third sweep ends the run
    adv(60);  mon_en = 1'b0;
    checks++; if ($countones(lg_done) !== 3) $display("FAIL cont_done_count: got %0d expected 3", $countones(lg_done)); else passed++;
    checks++; if ({lg_done[198], lg_done[132], lg_done[66]} !== 3'b111) $display("FAIL cont_done_pos: got %b expected 111", {lg_done[198], lg_done[132], lg_done[66]}); else passed++;
    checks++; if ({lg_rst[133], lg_rst[67:66]} !== 3'b110) $display("FAIL cont_rst_reentry: got %b expected 110", {lg_rst[133], lg_rst[67:66]}); else passed++;
    checks++; if (lg_sz[67:66] !== 2'b10) $display("FAIL cont_step_zero: got %b expected 10", lg_sz[67:66]); else passed++;
    checks++; if ($countones(lg_busy) !== 198) $display("FAIL cont_busy_len: got %0d expected 198", $countones(lg_busy)); else passed++;
    checks++; if (sweep_count !== 16'd5) $display("FAIL cont_sweep_count: got %0d expected 5", sweep_count); else passed++;
  endtask

  task automatic test_abort();
    begin_capture();
    start = 1'b1; mon_en = 1'b1;
    adv(1);  start = 1'b0;
    adv(42); abort = 1'b1;        // cycle 43: middle of tone-1 RECORD
    adv(1);  abort = 1'b0;
    adv(10); mon_en = 1'b0;
    checks++; if ({lg_busy[44:43], lg_rec[44:43]} !== 4'b0101) $display("FAIL abort_to_idle: got %b expected 0101", {lg_busy[44:43], lg_rec[44:43]}); else passed++;
    checks++; if ($countones(lg_rec) !== 12) $display("FAIL abort_rec_len: got %0d expected 12", $countones(lg_rec)); else passed++;
    checks++; if ($countones(lg_done) !== 0) $display("FAIL abort_no_done: got %0d expected 0", $countones(lg_done)); else passed++;
    checks++; if (sweep_count !== 16'd5) $display("FAIL abort_sweep_count: got %0d expected 5", sweep_count); else passed++;
    checks++; if (step_index !== 8'd1) $display("FAIL abort_step_hold: got %0d expected 1", step_index); else passed++;
    begin_capture();
    start = 1'b1; mon_en = 1'b1;
    adv(1);  start = 1'b0;
    adv(79); mon_en = 1'b0;
    checks++; if ($countones(lg_busy) !== 66) $display("FAIL abort_rerun_busy: got %0d expected 66", $countones(lg_busy)); else passed++;
    checks++; if (lg_done[66] !== 1'b1) $display("FAIL abort_rerun_done: got %b expected 1", lg_done[66]); else passed++;
    checks++; if (sweep_count !== 16'd6) $display("FAIL abort_rerun_count: got %0d expected 6", sweep_count); else passed++;
  endtask

  task automatic test_abort_start_idle();
    adv(2);
    abort = 1'b1; start = 1'b1;
    adv(1);
    abort = 1'b0; start = 1'b0;
    @(negedge clock);
    checks++; if ({busy, rx_reset} !== 2'b00) $display("FAIL abort_start_idle: got %b expected 00", {busy, rx_reset}); else passed++;
    adv(3);
    checks++; if (busy !== 1'b0) $display("FAIL abort_start_stay: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_resync();
    begin_capture();
    start = 1'b1; mon_en = 1'b1;
    adv(1);  start = 1'b0;
    adv(48); freq_step_reset_in = 1'b1;   // cycle 49: inside tone-1 STEP
    adv(1);  freq_step_reset_in = 1'b0;
    adv(80); mon_en = 1'b0;
    checks++; if (lg_rst[50:49] !== 2'b10) $display("FAIL resync_rst: got %b expected 10", lg_rst[50:49]); else passed++;
    checks++; if (lg_sz[50:49] !== 2'b10) $display("FAIL resync_step_zero: got %b expected 10", lg_sz[50:49]); else passed++;
    checks++; if (lg_fs[51:50] !== 2'b01) $display("FAIL resync_fs_low: got %b expected 01", lg_fs[51:50]); else passed++;
    checks++; if ($countones(lg_done[114:0]) !== 0) $display("FAIL resync_no_early_done: got %0d expected 0", $countones(lg_done[114:0])); else passed++;
    checks++; if (lg_done[115] !== 1'b1) $display("FAIL resync_done_pos: got %b expected 1", lg_done[115]); else passed++;
    checks++; if ($countones(lg_rst) !== 32) $display("FAIL resync_rst_len: got %0d expected 32", $countones(lg_rst)); else passed++;
    checks++; if (sweep_count !== 16'd7) $display("FAIL resync_sweep_count: got %0d expected 7", sweep_count); else passed++;
  endtask

  task automatic test_lock_timeout();
    begin_capture();
    pll_locked = 1'b0; start = 1'b1; mon_en = 1'b1;
    adv(1);  start = 1'b0;
    adv(59); mon_en = 1'b0;
    checks++; if ($countones(lg_rec) !== 0) $display("FAIL lockto_no_record: got %0d expected 0", $countones(lg_rec)); else passed++;
`ifdef FSQ_LOCK_TIMEOUT_EN
    checks++; if (lg_le[27:26] !== 2'b10) $display("FAIL lockto_err_set: got %b expected 10", lg_le[27:26]); else passed++;
    checks++; if ({lg_rst[27:26], lg_sz[27]} !== 3'b101) $display("FAIL lockto_reenter_reset: got %b expected 101", {lg_rst[27:26], lg_sz[27]}); else passed++;
    checks++; if (rises(lg_rst) !== 3) $display("FAIL lockto_retries: got %0d expected 3", rises(lg_rst)); else passed++;
    abort = 1'b1;
    adv(1);  abort = 1'b0;
    @(negedge clock);
    checks++; if ({lock_err, busy} !== 2'b10) $display("FAIL lockto_sticky: got %b expected 10", {lock_err, busy}); else passed++;
`else
    checks++; if ($countones(lg_le) !== 0) $display("FAIL lockto_err_tied: got %0d expected 0", $countones(lg_le)); else passed++;
    checks++; if ({busy, rx_reset} !== 2'b10) $display("FAIL lockto_wait_settle: got %b expected 10", {busy, rx_reset}); else passed++;
`endif
    adv(1);
    pll_locked = 1'b1;
`ifdef FSQ_LOCK_TIMEOUT_EN
    start = 1'b1;
    adv(1);  start = 1'b0;
    @(negedge clock);
    checks++; if ({lock_err, busy} !== 2'b01) $display("FAIL lockto_clear_on_start: got %b expected 01", {lock_err, busy}); else passed++;
`endif
    adv(70);
    checks++; if ({busy, lock_err} !== 2'b00) $display("FAIL lockto_finish: got %b expected 00", {busy, lock_err}); else passed++;
    checks++; if (sweep_count !== 16'd8) $display("FAIL lockto_sweep_count: got %0d expected 8", sweep_count); else passed++;
  endtask

  task automatic test_reset_midrun();
    adv(2);
    start = 1'b1;
    adv(1);  start = 1'b0;
    adv(44);
    checks++; if ({step_index, rx_record} !== 9'b000000011) $display("FAIL midrun_before: got %b expected 000000011", {step_index, rx_record}); else passed++;
    reset = 1'b1;
    adv(1);  reset = 1'b0;
    @(negedge clock);
    checks++; if ({rx_reset, rx_record, rx_next, freq_step_out, busy, sweep_done, lock_err} !== 7'b0) $display("FAIL midrun_outputs: got %b expected 0000000", {rx_reset, rx_record, rx_next, freq_step_out, busy, sweep_done, lock_err}); else passed++;
    checks++; if ({step_index, sweep_count} !== 24'd0) $display("FAIL midrun_state: got %0d/%0d expected 0/0", step_index, sweep_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_lock_gating();
    test_continuous();
    test_abort();
    test_abort_start_idle();
    test_resync();
    test_lock_timeout();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fast_square_sweep_ctrl.md
Name: fast_square_sweep_ctrl

Overview:
Parametrised frequency-sweep sequencer for the fast-square receive path. It drives the RX chain (reset, record, next) and the synthesizer step line across a sweep of NUM_FREQ_STEPS tones. Compared with the fixed 32-step controller it adds:
- configurable tick counts for every phase and a configurable multi-pulse step waveform;
- PLL-lock gating before each record window;
- single-shot or continuous sweep modes with start/abort handshake;
- step index, sweep-done and sweep-count status for host readback.

Parameters:
NUM_FREQ_STEPS, 32, tones per sweep (1..2^STEP_W)
STEP_W, 8, width of step_index
CNT_W, 20, width of the shared phase counter; every *_TICKS value must be < 2^CNT_W
RESET_TICKS, 1048575, cycles rx_reset is held at sweep start (>=1)
SETTLE_TICKS, 640, minimum settle cycles before each record (>=1)
RECORD_TICKS, 15000, cycles rx_record is high per tone (>=1)
STEP_PULSES, 2, high pulses on freq_step_out per tone advance (>=1)
STEP_PULSE_TICKS, 10, cycles per high pulse (>=1)
STEP_GAP_TICKS, 10, low cycles between pulses (>=1)
LOCK_TIMEOUT_TICKS, 65535, lock wait limit (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  begin a sweep; sampled only in IDLE
continuous  in  1  1 = restart the sweep automatically after completion; sampled at end of sweep
abort  in  1  return to IDLE immediately
freq_step_reset_in  in  1  external resync; restarts the sweep from RESET
pll_locked  in  1  synthesizer lock; synchronous to clock
rx_reset  out  1  RX chain reset
rx_record  out  1  RX record window
rx_next  out  1  one-cycle advance to the next RX buffer
freq_step_out  out  1  synthesizer step pulse train
step_index  out  STEP_W  current tone index
busy  out  1  high in any state other than IDLE
sweep_done  out  1  one-cycle pulse at sweep completion
sweep_count  out  16  completed sweeps; wraps 0xFFFF -> 0
lock_err  out  1  sticky lock timeout flag (0 unless the optional feature is compiled in)

Behaviour:
- reset:
  - state goes to IDLE;
  - counter, step_index, sweep_count, lock_err and freq_step_out clear to 0;
  - all outputs are 0 in the first cycle after reset.
- Reset is synchronous with clock and active-high.
- Phase counter: cleared on every state change (including a self-restart into RESET); otherwise increments by 1 each cycle.
- rx_reset, rx_record, rx_next and busy are decoded from the registered state (zero latency from state).
- freq_step_out is registered: it lags the STEP-state counter decode by one cycle.
- Priority, highest first: reset > abort > freq_step_reset_in > normal transitions.
- IDLE:
  - outputs low;
  - start=1 -> RESET;
  - freq_step_reset_in=1 -> RESET.
- RESET:
  - rx_reset=1; step_index forced to 0;
  - on counter == RESET_TICKS-1 -> SETTLE.
- SETTLE:
  - wait until counter >= SETTLE_TICKS-1 AND pll_locked=1, then -> RECORD;
  - if lock is lost, keep waiting, counter keeps running.
- RECORD:
  - rx_record=1 for exactly RECORD_TICKS cycles.
  - On the cycle where counter == RECORD_TICKS-1:
    - if step_index == NUM_FREQ_STEPS-1: sweep_done=1 and sweep_count+1 on the same edge, then -> RESET if continuous=1, else -> IDLE;
    - otherwise: rx_next=1 for this single cycle and -> STEP.
- STEP:
  - length = STEP_PULSES*STEP_PULSE_TICKS + (STEP_PULSES-1)*STEP_GAP_TICKS cycles;
  - freq_step_out decode is high during pulse windows and low during gaps;
  - last cycle -> SETTLE, with step_index +1 on the same edge.
- Boundary cases:
  - NUM_FREQ_STEPS=1: STEP is never entered and rx_next never fires.
  - abort in any state: IDLE next cycle; no sweep_done; step_index and sweep_count hold; freq_step_out low one cycle later.
  - freq_step_reset_in during RECORD/STEP: no sweep_done and no count increment.
  - start while busy: ignored.
  - abort and start asserted together in IDLE: stay in IDLE.

Optional Feature:
FSQ_LOCK_TIMEOUT_EN
- Defined:
  - a second counter runs while in SETTLE with pll_locked=0; it clears on entering SETTLE and whenever lock is seen;
  - when it reaches LOCK_TIMEOUT_TICKS: lock_err is set (sticky, cleared only by reset or start) and the FSM goes -> RESET, retrying the sweep from step 0.
- Undefined: SETTLE waits forever for lock and lock_err is tied to 0.

Test Plan:
Common parameters: NUM_FREQ_STEPS=3, RESET_TICKS=16, SETTLE_TICKS=4, RECORD_TICKS=8, STEP_PULSES=2, STEP_PULSE_TICKS=2, STEP_GAP_TICKS=3.
1. Single sweep: pll_locked=1, continuous=0, start pulse -> rx_reset high 16 cycles; three rx_record windows of 8 cycles each; exactly 2 rx_next pulses; freq_step_out pattern 1,1,0,0,0,1,1 per step; busy high 66 cycles; one sweep_done; sweep_count=1; step_index ends at 2; FSM back in IDLE.
2. Lock gating: drop pll_locked for 20 cycles in the second SETTLE -> rx_record delayed until 1 cycle after lock returns; record length still 8; waveform otherwise identical.
3. Continuous mode: continuous=1, run 3 sweeps -> sweep_done every 66 cycles; sweep_count=3; RESET re-entered after each sweep with step_index=0.
4. Abort: abort mid-RECORD of tone 1 -> IDLE next cycle; rx_record=0; no sweep_done; sweep_count unchanged; a new start runs a full 66-cycle sweep.
5. Resync: pulse freq_step_reset_in during STEP -> RESET next cycle; step_index=0; freq_step_out low within 1 cycle; sweep_count unchanged.
6. FSQ_LOCK_TIMEOUT_EN with LOCK_TIMEOUT_TICKS=10 and pll_locked held 0 -> lock_err=1 after 10 unlocked SETTLE cycles; FSM re-enters RESET; lock_err clears on the next start.
